// File: rtl/hamming_seq_ctrl_pkg.sv
// Shared definitions for the Hamming-distance sequencing controller:
// FSM state encoding and the width helper used to size counters and sums.
package hamming_seq_ctrl_pkg;

  // Controller states; kept as plain constants so legacy tooling can match the encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bits needed to represent the value v (v=64 -> 7, v=8 -> 4, v=1 -> 1).
  function automatic int bits_for(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_seq_ctrl_popcount.sv
// Combinational population count of one operand chunk.
// The output is wide enough to hold the all-ones count M.
import hamming_seq_ctrl_pkg::*;

module hamming_popcount #(
  parameter  int M  = 8,
  localparam int PW = bits_for(M)
) (
  input  logic [M-1:0]  bits,
  output logic [PW-1:0] count
);

  // Sum every bit of the chunk into a count of set bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < M; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Sequencing controller for a multi-cycle Hamming-distance engine.
// A start command opens a comparison; CC chunks of M bits then arrive one per
// valid/ready handshake, LSB chunk first. Each chunk's XOR popcount is added to
// a running total, and after the last chunk the distance and a threshold-match
// flag are published with a one-cycle done pulse. The result stays on o/match
// until the next comparison finishes or reset clears it.
import hamming_seq_ctrl_pkg::*;

module hamming_seq_ctrl #(
  parameter  int N  = 64,
  parameter  int CC = 8,
  localparam int M  = N / CC,
  localparam int DW = bits_for(N),
  localparam int CW = bits_for(CC),
  localparam int PW = bits_for(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] thresh,
  input  logic [M-1:0]  g_input,
  input  logic [M-1:0]  e_input,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic [CW-1:0] chunk_idx,
  output logic          done,
  output logic [DW-1:0] o,
  output logic          match
);

  logic [1:0]    state;
  logic [DW-1:0] acc;
  logic [DW-1:0] thr_q;
  logic [PW-1:0] chunk_count;
  logic [DW-1:0] sum_next;
  logic          accept;
  logic          last_chunk;

  // Only one chunk is combined per cycle, so a single popcount on the XOR suffices.
  hamming_popcount #(
    .M (M)
  ) u_popcount (
    .bits  (g_input ^ e_input),
    .count (chunk_count)
  );

  // Handshake and status flags are pure decodes of the state so they track it exactly.
  always_comb begin
    in_ready   = (state == ST_RUN);
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    accept     = in_valid && (state == ST_RUN);
    last_chunk = (chunk_idx == CW'(CC - 1));
    sum_next   = acc + DW'(chunk_count);
  end

  // FSM, accumulator, captured threshold and held result; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      thr_q     <= '0;
      chunk_idx <= '0;
      o         <= '0;
      match     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            acc       <= '0;
            chunk_idx <= '0;
            thr_q     <= thresh;
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc <= sum_next;
            if (last_chunk) begin
              o         <= sum_next;
              match     <= (sum_next <= thr_q);
              chunk_idx <= '0;
              state     <= ST_DONE;
            end else begin
              chunk_idx <= chunk_idx + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            acc       <= '0;
            chunk_idx <= '0;
            thr_q     <= thresh;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hamming_seq_ctrl.md
Name: hamming_seq_ctrl

Overview:
Sequencing controller for a multi-cycle Hamming-distance engine. It accepts a start command and then CC operand chunks of M=N/CC bits each, one chunk per valid/ready handshake. Per chunk it XORs the two operands, popcounts the result and adds the count to a running total. After the last chunk it reports the final distance, plus a threshold-match flag, for a garbled-circuit consumer.
It replaces free-running accumulation with explicit start/done framing and backpressure, so chunks can arrive with gaps.

Parameters:
N, 64, total operand width in bits; must be divisible by CC.
CC, 8, number of chunks (cycles) per comparison; CC>=1.
M, N/CC, derived localparam: chunk width.
DW, log2(N), derived localparam: distance width, where log2(v) = number of bits needed to represent v (log2(64)=7).
CW, log2(CC), derived localparam: chunk-index width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin a new comparison; sampled only in IDLE or DONE
thresh  in  DW  match threshold; captured on an accepted start
g_input  in  M  garbler operand chunk
e_input  in  M  evaluator operand chunk
in_valid  in  1  chunk present on g_input/e_input
in_ready  out  1  controller accepts a chunk this cycle
busy  out  1  comparison in progress
chunk_idx  out  CW  index of the next chunk expected (0..CC-1)
done  out  1  one-cycle pulse: result valid
o  out  DW  Hamming distance; held until the next accepted start
match  out  1  o <= captured thresh; held with o

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk. rst=1 has priority over all other inputs.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, chunk_idx=0, o=0, match=0, accumulator=0, captured thresh=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; clear accumulator and chunk_idx; capture thresh.
  - in_valid is ignored in IDLE.
- RUN:
  - busy=1 and in_ready=1 combinationally.
  - Accept = in_valid & in_ready. On accept: acc <= acc + popcount(g_input ^ e_input), zero-extended to DW; chunk_idx <= chunk_idx+1.
  - No accept means no state change; gaps of any length are legal.
  - start is ignored while in RUN.
- Last chunk: on the accept with chunk_idx==CC-1, in the same edge:
  - o <= final sum;
  - match <= (final sum <= thresh);
  - done <= 1;
  - chunk_idx <= 0;
  - state -> DONE.
- Latency: done asserts the cycle after the CC-th accept. With back-to-back valid, done is high CC+1 cycles after the start cycle.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0, in_ready=0.
  - Next state is IDLE. If start=1 during DONE, go straight to RUN; this allows back-to-back comparisons with a one-cycle bubble.
  - done is 0 in every other state.
- Result hold: o and match change only at the end of a comparison or on reset. A new start does not clear them.
- Width: the accumulator is DW bits. The maximum sum N fits in DW bits, so overflow is impossible.
- CC=1: RUN accepts a single chunk, then goes to DONE. chunk_idx is held at 0, using a 1-bit width.
- Reset mid-operation: all partial state is discarded, done is not pulsed, and o is cleared to 0.
- Chunk ordering: chunks arrive LSB chunk first. Order does not affect the sum but is fixed for consistency.

Decomposition:
- Shared package: the log2 width function and the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module: the combinational popcount is a natural sub-module, hamming_popcount (M bits in, log2(M) bits out). It is instantiated once, on the XOR of the chunk operands.
- The accumulator, threshold compare and FSM stay in hamming_seq_ctrl.

Test Plan:
- N=64, CC=8. Reset, start, then 8 back-to-back chunks with g=8'hFF, e=8'h00 and thresh=64 -> done pulses on cycle 9 after start; o=64, match=1.
- Chunks with g^e = 8'h01, 8'h03, 8'h07, 8'h0F, 0, 0, 0, 0 and thresh=9 -> o=10, match=0. Repeat with thresh=10 -> match=1.
- Same data with in_valid deasserted for 3 cycles between chunks 2 and 3 -> o=10; chunk_idx stalls at 3; done arrives 3 cycles later than the gapless run.
- Pulse start during RUN and in_valid during IDLE -> neither has any effect. Then pulse start during the DONE cycle -> RUN is entered the next cycle with acc=0, and the previous o is held until the new done.
- Assert rst after 4 accepted chunks -> next cycle state=IDLE, o=0, done=0, chunk_idx=0. A fresh all-equal comparison then gives o=0, match=1.
- Parameter sweep CC=1 (M=64) and CC=64 (M=1) with random operands -> o equals the reference popcount of G^E.
